// File: rtl/mem_stage.sv
// mem_stage -- RISC-V memory stage.
//   Takes the EX result (address or pass-through value) plus store data,
//   runs loads/stores on a req/gnt/rvalid data-memory port and hands one
//   write-back record per instruction to WB. Stalls EX (ex_ready=0) while
//   an access is outstanding.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   ex_*              instruction from EX (valid/ready handshake)
//   dmem_*            data-memory request/grant/response port
//   wb_*              registered write-back record (wb_valid is a 1-cycle pulse)

// Per-byte-lane store path: byte enable and the byte driven on this lane.
module mem_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0]  size,   // 0 byte, 1 half, 2 word
  input  logic [1:0]  a,      // address[1:0]
  input  logic [31:0] rs2,
  output logic        be,
  output logic [7:0]  wbyte
);
  localparam logic [1:0] L = LANE[1:0];

  always_comb begin
    be    = 1'b1;
    wbyte = rs2[8*LANE +: 8];
    case (size)
      2'd0: begin
        be    = (a == L);
        wbyte = rs2[7:0];                 // byte replicated on every lane
      end
      2'd1: begin
        be    = (a[1] == L[1]);
        wbyte = rs2[8*(LANE%2) +: 8];     // halfword replicated on both halves
      end
      default: ;
    endcase
  end
endmodule

module mem_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_rs2_data,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic [2:0]      ex_funct3,
  input  logic [4:0]      ex_rd,
  input  logic            ex_reg_we,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic            wb_we,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_misaligned
);
  localparam int NUM_LANES = XLEN / 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  // Op context held across REQ/WAIT.
  typedef struct packed {
    logic       ld;
    logic [2:0] f3;
    logic [1:0] a;
    logic [4:0] rd;
    logic       reg_we;
  } op_t;

  logic [1:0] state;
  op_t        op;

  assign ex_ready = (state == IDLE);

  logic accept, is_mem, misal;
  logic [1:0] sz;

  assign accept = ex_valid && ex_ready;
  assign is_mem = ex_mem_read || ex_mem_write;
  // funct3[1:0]: 00 byte, 01 half, anything else (incl. invalid codes) word
  assign sz     = (ex_funct3[1:0] == 2'b00) ? 2'd0 :
                  (ex_funct3[1:0] == 2'b01) ? 2'd1 : 2'd2;
  assign misal  = (sz == 2'd1 && ex_alu_result[0]) ||
                  (sz == 2'd2 && ex_alu_result[1:0] != 2'b00);

  logic [NUM_LANES-1:0]      be_n;
  logic [NUM_LANES-1:0][7:0] wd_n;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    mem_lane #(.LANE(i)) u_lane (
      .size  (sz),
      .a     (ex_alu_result[1:0]),
      .rs2   (ex_rs2_data),
      .be    (be_n[i]),
      .wbyte (wd_n[i])
    );
  end

  // Load lane select and extension, using the latched funct3/offset.
  logic [7:0]      lb;
  logic [15:0]     lh;
  logic [XLEN-1:0] ld_ext;

  always_comb begin
    case (op.a)
      2'd0:    lb = dmem_rdata[7:0];
      2'd1:    lb = dmem_rdata[15:8];
      2'd2:    lb = dmem_rdata[23:16];
      default: lb = dmem_rdata[31:24];
    endcase
    lh = op.a[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (op.f3)
      3'b000:  ld_ext = {{24{lb[7]}}, lb};
      3'b001:  ld_ext = {{16{lh[15]}}, lh};
      3'b100:  ld_ext = {24'd0, lb};
      3'b101:  ld_ext = {16'd0, lh};
      default: ld_ext = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      op            <= '0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_be       <= '0;
      dmem_wdata    <= '0;
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_we         <= 1'b0;
      wb_data       <= '0;
      wb_misaligned <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!is_mem) begin
              wb_valid      <= 1'b1;
              wb_rd         <= ex_rd;
              wb_we         <= ex_reg_we;
              wb_data       <= ex_alu_result;
              wb_misaligned <= 1'b0;
            end else if (misal) begin
              // Faulting address goes out on wb_data for the trap path.
              wb_valid      <= 1'b1;
              wb_rd         <= ex_rd;
              wb_we         <= 1'b0;
              wb_data       <= ex_alu_result;
              wb_misaligned <= 1'b1;
            end else begin
              op         <= '{ld: ex_mem_read, f3: ex_funct3, a: ex_alu_result[1:0],
                              rd: ex_rd, reg_we: ex_reg_we};
              dmem_req   <= 1'b1;
              dmem_we    <= ex_mem_write;
              dmem_addr  <= {ex_alu_result[XLEN-1:2], 2'b00};
              dmem_be    <= be_n;
              dmem_wdata <= wd_n;
              state      <= REQ;
            end
          end
        end
        REQ: begin
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            if (op.ld) begin
              state <= WAIT;
            end else begin
              wb_valid      <= 1'b1;
              wb_rd         <= op.rd;
              wb_we         <= 1'b0;
              wb_data       <= {dmem_addr[XLEN-1:2], op.a};
              wb_misaligned <= 1'b0;
              state         <= IDLE;
            end
          end
        end
        WAIT: begin
          if (dmem_rvalid) begin
            wb_valid      <= 1'b1;
            wb_rd         <= op.rd;
            wb_we         <= op.reg_we;
            wb_data       <= ld_ext;
            wb_misaligned <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_alu_result, ex_rs2_data;
  logic        ex_mem_read, ex_mem_write;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic        ex_reg_we;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_we;
  logic [31:0] wb_data;
  logic        wb_misaligned;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_result(ex_alu_result), .ex_rs2_data(ex_rs2_data),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_funct3(ex_funct3), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_we(wb_we),
    .wb_data(wb_data), .wb_misaligned(wb_misaligned)
  );

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic rd_op, input logic wr_op, input logic [31:0] addr,
                       input logic [31:0] rs2, input logic [2:0] f3,
                       input logic [4:0] rd, input logic we);
    ex_valid      = 1'b1;
    ex_mem_read   = rd_op;
    ex_mem_write  = wr_op;
    ex_alu_result = addr;
    ex_rs2_data   = rs2;
    ex_funct3     = f3;
    ex_rd         = rd;
    ex_reg_we     = we;
  endtask

  task automatic idle_ex();
    ex_valid     = 1'b0;
    ex_mem_read  = 1'b0;
    ex_mem_write = 1'b0;
  endtask

  // Load with gnt in the first REQ cycle and rvalid after 'dly' extra cycles.
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [3:0] exp_be, input logic [31:0] exp, input int dly);
    issue(1'b1, 1'b0, addr, 32'h0, f3, 5'd5, 1'b1);
    tick();
    idle_ex();
    chk({tag, ".req"},  {31'd0, dmem_req}, 32'd1);
    chk({tag, ".we"},   {31'd0, dmem_we}, 32'd0);
    chk({tag, ".addr"}, dmem_addr, {addr[31:2], 2'b00});
    chk({tag, ".be"},   {28'd0, dmem_be}, {28'd0, exp_be});
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    chk({tag, ".req_drop"}, {31'd0, dmem_req}, 32'd0);
    chk({tag, ".rdy_wait"}, {31'd0, ex_ready}, 32'd0);
    for (int i = 0; i < dly; i++) begin
      tick();
      chk({tag, ".rdy_dly"}, {31'd0, ex_ready}, 32'd0);
      chk({tag, ".wbv_dly"}, {31'd0, wb_valid}, 32'd0);
    end
    dmem_rvalid = 1'b1;
    tick();
    dmem_rvalid = 1'b0;
    chk({tag, ".wbv"},  {31'd0, wb_valid}, 32'd1);
    chk({tag, ".data"}, wb_data, exp);
    chk({tag, ".rd"},   {27'd0, wb_rd}, 32'd5);
    chk({tag, ".wbwe"}, {31'd0, wb_we}, 32'd1);
    chk({tag, ".rdy"},  {31'd0, ex_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_ex();
    ex_alu_result = '0; ex_rs2_data = '0; ex_funct3 = '0; ex_rd = '0; ex_reg_we = 1'b0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h8000_F0FF;

    // Reset state
    tick(); tick();
    chk("rst.req",  {31'd0, dmem_req}, 32'd0);
    chk("rst.wbv",  {31'd0, wb_valid}, 32'd0);
    chk("rst.addr", dmem_addr, 32'd0);
    chk("rst.wbd",  wb_data, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst.rdy",  {31'd0, ex_ready}, 32'd1);

    // Pass-through, back to back
    issue(1'b0, 1'b0, 32'h8000_0000, 32'h0, 3'b000, 5'd1, 1'b1);
    tick();
    chk("pt1.wbv", {31'd0, wb_valid}, 32'd1);
    chk("pt1.data", wb_data, 32'h8000_0000);
    chk("pt1.rd", {27'd0, wb_rd}, 32'd1);
    issue(1'b0, 1'b0, 32'h4000_0000, 32'h0, 3'b000, 5'd2, 1'b1);
    tick();
    chk("pt2.wbv", {31'd0, wb_valid}, 32'd1);
    chk("pt2.data", wb_data, 32'h4000_0000);
    chk("pt2.rd", {27'd0, wb_rd}, 32'd2);
    chk("pt2.req", {31'd0, dmem_req}, 32'd0);
    issue(1'b0, 1'b0, 32'h00F0_00F0, 32'h0, 3'b000, 5'd3, 1'b1);
    tick();
    idle_ex();
    chk("pt3.wbv", {31'd0, wb_valid}, 32'd1);
    chk("pt3.data", wb_data, 32'h00F0_00F0);
    chk("pt3.rd", {27'd0, wb_rd}, 32'd3);
    chk("pt3.we", {31'd0, wb_we}, 32'd1);
    tick();
    chk("pt.end", {31'd0, wb_valid}, 32'd0);
    chk("pt.req", {31'd0, dmem_req}, 32'd0);

    // SB at 0x1003 with gnt held low 3 cycles
    issue(1'b0, 1'b1, 32'h0000_1003, 32'h1234_56AB, 3'b000, 5'd0, 1'b0);
    tick();
    idle_ex();
    chk("sb.addr", dmem_addr, 32'h0000_1000);
    chk("sb.be", {28'd0, dmem_be}, 32'h8);
    chk("sb.wdata", dmem_wdata, 32'hABAB_ABAB);
    chk("sb.we", {31'd0, dmem_we}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("sb.req_hold", {31'd0, dmem_req}, 32'd1);
      chk("sb.rdy_hold", {31'd0, ex_ready}, 32'd0);
      chk("sb.wbv_hold", {31'd0, wb_valid}, 32'd0);
      if (i < 2) tick();
    end
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    chk("sb.wbv", {31'd0, wb_valid}, 32'd1);
    chk("sb.wbwe", {31'd0, wb_we}, 32'd0);
    chk("sb.mis", {31'd0, wb_misaligned}, 32'd0);
    chk("sb.req_off", {31'd0, dmem_req}, 32'd0);
    chk("sb.rdy", {31'd0, ex_ready}, 32'd1);
    tick();
    chk("sb.pulse", {31'd0, wb_valid}, 32'd0);

    // SH at 0x1002, zero-wait gnt: store latency 2
    issue(1'b0, 1'b1, 32'h0000_1002, 32'hAABB_CCDD, 3'b001, 5'd0, 1'b0);
    tick();
    idle_ex();
    chk("sh.be", {28'd0, dmem_be}, 32'hC);
    chk("sh.wdata", dmem_wdata, 32'hCCDD_CCDD);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    chk("sh.wbv", {31'd0, wb_valid}, 32'd1);

    // Loads of 0x8000_F0FF
    do_load("lb",  32'h0000_2000, 3'b000, 4'b0001, 32'hFFFF_FFFF, 0);
    do_load("lbu", 32'h0000_2001, 3'b100, 4'b0010, 32'h0000_00F0, 0);
    do_load("lh",  32'h0000_2002, 3'b001, 4'b1100, 32'hFFFF_8000, 0);
    do_load("lhu", 32'h0000_2002, 3'b101, 4'b1100, 32'h0000_8000, 0);
    do_load("lw",  32'h0000_2000, 3'b010, 4'b1111, 32'h8000_F0FF, 2);

    // Misaligned LW then LH, back to back
    issue(1'b1, 1'b0, 32'h0000_2002, 32'h0, 3'b010, 5'd7, 1'b1);
    tick();
    chk("mlw.wbv", {31'd0, wb_valid}, 32'd1);
    chk("mlw.mis", {31'd0, wb_misaligned}, 32'd1);
    chk("mlw.we", {31'd0, wb_we}, 32'd0);
    chk("mlw.req", {31'd0, dmem_req}, 32'd0);
    chk("mlw.rdy", {31'd0, ex_ready}, 32'd1);
    issue(1'b1, 1'b0, 32'h0000_2001, 32'h0, 3'b001, 5'd8, 1'b1);
    tick();
    idle_ex();
    chk("mlh.wbv", {31'd0, wb_valid}, 32'd1);
    chk("mlh.mis", {31'd0, wb_misaligned}, 32'd1);
    chk("mlh.we", {31'd0, wb_we}, 32'd0);
    chk("mlh.rd", {27'd0, wb_rd}, 32'd8);
    chk("mlh.req", {31'd0, dmem_req}, 32'd0);
    tick();
    chk("mis.req", {31'd0, dmem_req}, 32'd0);

    // Stray rvalid while idle
    dmem_rvalid = 1'b1;
    tick();
    dmem_rvalid = 1'b0;
    chk("stray.wbv", {31'd0, wb_valid}, 32'd0);
    tick();
    chk("stray.wbv2", {31'd0, wb_valid}, 32'd0);

    // Reset mid-REQ
    issue(1'b0, 1'b1, 32'h0000_3000, 32'hDEAD_BEEF, 3'b010, 5'd0, 1'b0);
    tick();
    idle_ex();
    chk("rq.req", {31'd0, dmem_req}, 32'd1);
    chk("rq.wdata", dmem_wdata, 32'hDEAD_BEEF);
    chk("rq.be", {28'd0, dmem_be}, 32'hF);
    rst_n = 1'b0;
    tick();
    chk("rq.req_rst", {31'd0, dmem_req}, 32'd0);
    chk("rq.wbv_rst", {31'd0, wb_valid}, 32'd0);
    tick();
    rst_n = 1'b1;
    chk("rq.addr_rst", dmem_addr, 32'd0);
    chk("rq.rdy", {31'd0, ex_ready}, 32'd1);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    chk("rq.gnt_ign", {31'd0, wb_valid}, 32'd0);
    chk("rq.req_ign", {31'd0, dmem_req}, 32'd0);
    chk("rq.rdy2", {31'd0, ex_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the RISC-V pipeline. It takes the EX-stage ALU result (effective address or pass-through value) and store data, performs loads and stores against the data-memory port with a request/grant/response handshake, and presents one write-back record per instruction to WB. Its features are byte/halfword lane selection, sign/zero extension and misalignment detection. It stalls EX through `ex_ready` while a memory access is outstanding.

## Interface
Parameters:
- `XLEN`, 32, data/address width (only 32 supported)

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous active-low reset
- `ex_valid`  in  1  EX presents an instruction
- `ex_ready`  out  1  stage can accept; transfer when `ex_valid && ex_ready`
- `ex_alu_result`  in  32  address (mem op) or result (non-mem op)
- `ex_rs2_data`  in  32  store data
- `ex_mem_read`  in  1  load
- `ex_mem_write`  in  1  store (never both with `ex_mem_read`)
- `ex_funct3`  in  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- `ex_rd`  in  5  destination register
- `ex_reg_we`  in  1  instruction writes `rd`
- `dmem_req`  out  1  memory request
- `dmem_we`  out  1  1 = store
- `dmem_addr`  out  32  word-aligned address (`[1:0]`=0)
- `dmem_be`  out  4  byte enables
- `dmem_wdata`  out  32  lane-replicated store data
- `dmem_gnt`  in  1  request accepted this cycle
- `dmem_rvalid`  in  1  load data valid
- `dmem_rdata`  in  32  load data word
- `wb_valid`  out  1  one-cycle pulse, write-back record valid
- `wb_rd`  out  5  destination
- `wb_we`  out  1  register write enable
- `wb_data`  out  32  write-back value
- `wb_misaligned`  out  1  access faulted; no memory traffic, `wb_we`=0

## Operation
- FSM states: IDLE, REQ, WAIT.
- `ex_ready` = (state == IDLE).
- IDLE, accept, non-mem op: register `wb_*` (`wb_data`=`ex_alu_result`, `wb_we`=`ex_reg_we`). Stay in IDLE.
- IDLE, accept, mem op, misaligned: H with `addr[0]`=1, or W with `addr[1:0]`≠0. Emit a WB record with `wb_misaligned`=1 and `wb_we`=0. Stay in IDLE.
- IDLE, accept, aligned mem op: latch the op, go to REQ.
- REQ: `dmem_req`=1 with stable addr/be/wdata/we until `dmem_gnt`.
  - Gnt on a store: emit WB record (`wb_we`=0), go to IDLE.
  - Gnt on a load: go to WAIT.
- WAIT: on `dmem_rvalid`, capture the extended data into `wb_data`, emit WB, go to IDLE. `dmem_rvalid` outside WAIT is ignored.
- Byte enables, with `a` = `addr[1:0]`:
  - B: `1<<a`
  - H: `4'b0011<<a`
  - W: `4'b1111`
- Store data:
  - SB: byte replicated ×4
  - SH: half replicated ×2
  - SW: as is
- Load data: select lane `a`. B/H sign-extend bit 7/15; BU/HU zero-extend; W unchanged.
- Invalid funct3 on a mem op is treated as W.

## Timing
- Reset (`rst_n`=0 at a clock edge) forces:
  - state IDLE
  - `dmem_req`=0, `dmem_we`=0, `dmem_addr`=0, `dmem_be`=0, `dmem_wdata`=0
  - `wb_valid`=0, `wb_rd`=0, `wb_we`=0, `wb_data`=0, `wb_misaligned`=0
  - `ex_ready` reads 1 once reset is released.
- Reset mid-access abandons the access; later `dmem_gnt`/`rvalid` are ignored until a new request.
- All outputs are registered except `ex_ready`.
- `wb_valid` is high for exactly one cycle per accepted instruction; records stay in order.
- Latency, counted from the accept edge N:
  - Non-mem or misaligned: `wb_valid` at N+1.
  - Mem op: `dmem_req` high from N+1.
  - Store, gnt sampled at edge G: `wb_valid` in cycle G+1, `dmem_req` low in G+1, `ex_ready` high in G+1.
  - Load, rvalid sampled at edge R: `wb_valid` in R+1.
- Zero-wait memory (gnt in the first REQ cycle, rvalid in the next) gives a load latency of 3 cycles and a store latency of 2.
- `dmem_rvalid` never coincides with the gnt cycle of the same request.
- Back-to-back non-mem ops sustain one per cycle.

## Test plan
- Reset: `rst_n`=0 for 2 cycles mid-REQ -> `dmem_req`=0 and `wb_valid`=0 the next cycle; `ex_ready`=1 after release.
- Pass-through: 3 consecutive ALU ops (`0x8000_0000`, `0x4000_0000`, `0x00F0_00F0`, rd 1/2/3) -> `wb_valid` on 3 consecutive cycles with matching data/rd; `dmem_req` never asserted.
- Store SB, addr `0x1003`, rs2 `0x1234_56AB` -> `dmem_addr`=`0x1000`, `be`=`1000`, `wdata`=`0xABAB_ABAB`. Hold gnt low 3 cycles: req held, `ex_ready`=0. After gnt, `wb_valid` with `wb_we`=0.
- Loads of word `0x8000_F0FF` at `0x2000`:
  - LB `0x2000` -> `0xFFFF_FFFF`
  - LBU `0x2001` -> `0x0000_00F0`
  - LH `0x2002` -> `0xFFFF_8000`
  - LHU `0x2002` -> `0x0000_8000`
  - LW -> `0x8000_F0FF`
  - With rvalid delayed 2 cycles: `ex_ready` stays 0 until WB.
- Misaligned LW at `0x2002` and LH at `0x2001` -> `wb_misaligned`=1 at N+1, `wb_we`=0, no `dmem_req`.
- Stray `dmem_rvalid` while IDLE -> no `wb_valid`.
